// File: rtl/lu_decomp_fx.sv
// lu_decomp_fx: in-place Doolittle LU decomposition of an N x N signed fixed-point matrix
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    one-cycle request, inp sampled on the same edge (accepted only when idle)
//   inp      packed matrix, element (r,c) at [((N*N-1-(r*N+c))*DW) +: DW], (0,0) in the MSBs
//   ans      packed L\U result in the same layout (unit L diagonal implicit), held until next finish
//   done     one-cycle pulse when ans is valid
//   busy     high from the start-accept edge through the done cycle
//   singular valid with done, a zero pivot was met
//   ovf      valid with done, a division or update saturated (only with LU_OVF_FLAG_EN defined)
module lu_decomp_fx #(
    parameter int N    = 4,
    parameter int DW   = 32,
    parameter int FRAC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*N*DW-1:0] inp,
    output logic [N*N*DW-1:0] ans,
    output logic              done,
    output logic              busy,
`ifdef LU_OVF_FLAG_EN
    output logic              ovf,
`endif
    output logic              singular
);
    localparam int Q  = DW + FRAC;
    localparam int WW = 2 * DW + 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(Q);
    localparam logic [KW-1:0] LAST = KW'(N - 1);
    localparam logic [KW-1:0] PEN  = KW'(N - 2);
    localparam logic [CW-1:0] QTOP = CW'(Q - 1);

    typedef enum logic [2:0] {S_IDLE, S_PIVOT, S_DIV, S_WRL, S_UPD, S_FIN} state_t;

    state_t               r_state;
    logic signed [DW-1:0] r_a [N][N];
    logic [KW-1:0]        r_k, r_i, r_j;
    logic [CW-1:0]        r_cnt;
    logic [DW-2:0]        r_rem;
    logic [Q-1:0]         r_quo;
    logic signed [DW-1:0] r_l;
    logic [N*N*DW-1:0]    r_ans;
    logic                 r_done, r_busy, r_sing;
`ifdef LU_OVF_FLAG_EN
    logic                 r_ovf;
    assign ovf = r_ovf;
`endif

    assign ans      = r_ans;
    assign done     = r_done;
    assign busy     = r_busy;
    assign singular = r_sing;

    // True when a wide two's-complement value is representable in DW bits
    function automatic logic fits(input logic [WW-1:0] x);
        return (&x[WW-1:DW-1]) | ~(|x[WW-1:DW-1]);
    endfunction

    function automatic logic [DW-1:0] sat(input logic [WW-1:0] x);
        return fits(x) ? x[DW-1:0] : {x[WW-1], {(DW-1){~x[WW-1]}}};
    endfunction

    logic signed [DW-1:0]   w_akk, w_aik, w_akj, w_aij;
    logic [DW-1:0]          w_dvs, w_aik_abs, w_sh, w_l, w_u;
    logic [Q-1:0]           w_num;
    logic                   w_ge, w_neg;
    logic signed [Q:0]      w_lq;
    logic [WW-1:0]          w_lx, w_dx;
    logic signed [2*DW-1:0] w_prod, w_psh;
    logic [N*N*DW-1:0]      w_flat;

    assign w_akk     = r_a[r_k][r_k];
    assign w_aik     = r_a[r_i][r_k];
    assign w_akj     = r_a[r_k][r_j];
    assign w_aij     = r_a[r_i][r_j];
    // Magnitudes as unsigned DW bits; -2^(DW-1) maps correctly to 2^(DW-1)
    assign w_dvs     = w_akk[DW-1] ? -w_akk : w_akk;
    assign w_aik_abs = w_aik[DW-1] ? -w_aik : w_aik;
    assign w_num     = Q'(w_aik_abs) << FRAC;
    // Restoring step: dividend bits are fed MSB first straight from the array,
    // which stays untouched until the quotient is written back
    assign w_sh      = {r_rem, w_num[r_cnt]};
    assign w_ge      = w_sh >= w_dvs;
    assign w_neg     = w_aik[DW-1] ^ w_akk[DW-1];
    assign w_lq      = w_neg ? -$signed({1'b0, r_quo}) : $signed({1'b0, r_quo});
    assign w_lx      = {{(WW-Q-1){w_lq[Q]}}, w_lq};
    assign w_prod    = r_l * w_akj;
    assign w_psh     = w_prod >>> FRAC;
    // Difference kept exact at full width so saturation never sees a wrapped value
    assign w_dx      = {{(DW+1){w_aij[DW-1]}}, w_aij} - {w_psh[2*DW-1], w_psh};
    assign w_l       = sat(w_lx);
    assign w_u       = sat(w_dx);

    for (genvar r = 0; r < N; r++) begin : g_r
        for (genvar c = 0; c < N; c++) begin : g_c
            assign w_flat[(N*N-1-(r*N+c))*DW +: DW] = r_a[r][c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ans   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_sing  <= 1'b0;
            r_k     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_cnt   <= QTOP;
            r_rem   <= '0;
            r_quo   <= '0;
            r_l     <= '0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    r_a[r][c] <= '0;
`ifdef LU_OVF_FLAG_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            // Divider is re-armed in every state other than DIV
            if (r_state != S_DIV) begin
                r_cnt <= QTOP;
                r_rem <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    // busy is still high in the done cycle, so a start there is dropped
                    if (start && !r_busy) begin
                        for (int r = 0; r < N; r++)
                            for (int c = 0; c < N; c++)
                                r_a[r][c] <= inp[(N*N-1-(r*N+c))*DW +: DW];
                        r_k     <= '0;
                        r_sing  <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef LU_OVF_FLAG_EN
                        r_ovf   <= 1'b0;
`endif
                        r_state <= S_PIVOT;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_PIVOT: begin
                    if (w_akk == '0) begin
                        r_sing  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_i     <= r_k + 1'b1;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= (DW-1)'(w_ge ? w_sh - w_dvs : w_sh);
                    r_quo <= {r_quo[Q-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_WRL;
                end
                S_WRL: begin
                    r_a[r_i][r_k] <= w_l;
                    r_l           <= w_l;
                    r_j           <= r_k + 1'b1;
`ifdef LU_OVF_FLAG_EN
                    r_ovf         <= r_ovf | ~fits(w_lx);
`endif
                    r_state       <= S_UPD;
                end
                S_UPD: begin
                    r_a[r_i][r_j] <= w_u;
`ifdef LU_OVF_FLAG_EN
                    r_ovf         <= r_ovf | ~fits(w_dx);
`endif
                    if (r_j != LAST) begin
                        r_j <= r_j + 1'b1;
                    end else if (r_i != LAST) begin
                        r_i     <= r_i + 1'b1;
                        r_state <= S_DIV;
                    end else if (r_k == PEN) begin
                        r_state <= S_FIN;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= S_PIVOT;
                    end
                end
                S_FIN: begin
                    r_ans   <= w_flat;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lu_decomp_fx.sv
module tb_lu_decomp_fx;
    localparam int N = 4, DW = 32, FRAC = 16, Q = DW + FRAC, W = N * N * DW;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] inp = '0, ans;
    logic         done, busy, singular;
`ifdef LU_OVF_FLAG_EN
    logic         ovf;
`endif
    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    lu_decomp_fx #(.N(N), .DW(DW), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .inp(inp), .ans(ans),
        .done(done), .busy(busy),
`ifdef LU_OVF_FLAG_EN
        .ovf(ovf),
`endif
        .singular(singular)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] el(input logic [W-1:0] m, input int r, input int c);
        return m[(N*N-1-(r*N+c))*DW +: DW];
    endfunction

    function automatic logic [W-1:0] setel(input logic [W-1:0] m, input int r, input int c,
                                           input logic [DW-1:0] v);
        m[(N*N-1-(r*N+c))*DW +: DW] = v;
        return m;
    endfunction

    function automatic logic [W-1:0] mkq(input int e[N*N]);
        logic [W-1:0] m = '0;
        for (int i = 0; i < N * N; i++) m = setel(m, i / N, i % N, DW'(longint'(e[i]) <<< FRAC));
        return m;
    endfunction

    function automatic logic [W-1:0] mkrand(input int span, input bit nz);
        logic [W-1:0] m = '0;
        int v;
        for (int i = 0; i < N * N; i++) begin
            v = nz ? int'($urandom_range(1, span)) : int'($urandom_range(0, 2 * span)) - span;
            if (nz && $urandom_range(0, 1) == 1) v = -v;
            m = setel(m, i / N, i % N, DW'(v));
        end
        return m;
    endfunction

    function automatic longint sat(input longint x);
        return x > MAXV ? MAXV : (x < MINV ? MINV : x);
    endfunction

    // Reference: textbook Doolittle elimination on plain integers with the
    // stated rounding and clamping, plus the closed-form latency
    function automatic void model(input logic [W-1:0] m, output logic [W-1:0] res,
                                  output bit sing, output bit ov, output int lat);
        longint a[N][N];
        longint num, den, q, l, t;
        sing = 0; ov = 0; lat = 2;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) a[r][c] = longint'($signed(el(m, r, c)));
        for (int k = 0; k < N - 1 && !sing; k++) begin
            lat++;
            if (a[k][k] == 0) begin
                sing = 1;
            end else begin
                lat += (N - 1 - k) * (Q + 1 + N - 1 - k);
                for (int i = k + 1; i < N; i++) begin
                    num = a[i][k]; den = a[k][k];
                    q = ((num < 0 ? -num : num) <<< FRAC) / (den < 0 ? -den : den);
                    if ((num < 0) != (den < 0)) q = -q;
                    l = sat(q);
                    if (l != q) ov = 1;
                    a[i][k] = l;
                    for (int j = k + 1; j < N; j++) begin
                        t = a[i][j] - ((l * a[k][j]) >>> FRAC);
                        if (sat(t) != t) ov = 1;
                        a[i][j] = sat(t);
                    end
                end
            end
        end
        res = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) res = setel(res, r, c, DW'(a[r][c]));
    endfunction

    // Starts one operation and watches 400 cycles; cycle n is the n-th cycle after the start edge
    task automatic do_case(input string tag, input logic [W-1:0] m, input int pulse_at,
                           input logic [W-1:0] m2, output logic [W-1:0] res);
        int lat = 0, ndone = 0, elat;
        logic sing = 0, ov = 0, busy_in = 0, busy_after = 1;
        logic [W-1:0] exp;
        bit esing, eov;
        res = '0;
        @(negedge clk); inp = m; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc == 2) busy_in = busy;
            if (lat != 0 && cyc == lat + 1) busy_after = busy;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = cyc; res = ans; sing = singular;
`ifdef LU_OVF_FLAG_EN
                    ov = ovf;
`endif
                end
            end
            start = (cyc == pulse_at);
            if (cyc == pulse_at) inp = m2;
            @(negedge clk);
        end
        model(m, exp, esing, eov, elat);
        chk({tag, "_lat"}, W'(lat), W'(elat));
        chk({tag, "_ndone"}, W'(ndone), W'(1));
        chk({tag, "_sing"}, W'(sing), W'(esing));
        chk({tag, "_busy_in"}, W'(busy_in), W'(1));
        chk({tag, "_busy_after"}, W'(busy_after), W'(0));
`ifdef LU_OVF_FLAG_EN
        chk({tag, "_ovf"}, W'(ov), W'(eov));
`else
        if (ov) chk({tag, "_ovf_absent"}, W'(ov), W'(0));
`endif
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                chk($sformatf("%s_a%0d%0d", tag, r, c), W'(el(res, r, c)), W'(el(exp, r, c)));
    endtask

    initial begin
        logic [W-1:0] res, m, msat, mnew;
        logic seen;
        int plan[N*N] = '{2, 3, 4, 1, 3, 4, 1, 2, 4, 1, 2, 3, 1, 2, 3, 4};
        int ident[N*N] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int late[N*N] = '{1, 2, 3, 4, 2, 4, 1, 1, 3, 1, 2, 1, 4, 2, 1, 3};

        #3 rst = 1'b0;
        #1;
        chk("rst_ans", ans, '0);
        chk("rst_done", W'(done), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_sing", W'(singular), W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_case("plan", mkq(plan), 0, '0, res);
        chk("plan10", W'(el(res, 1, 0)), W'(32'h00018000));
        chk("plan11", W'(el(res, 1, 1)), W'(32'hFFFF8000));
        chk("plan12", W'(el(res, 1, 2)), W'(32'hFFFB0000));
        chk("plan13", W'(el(res, 1, 3)), W'(32'h00008000));
        chk("plan21", W'(el(res, 2, 1)), W'(32'h000A0000));
        chk("plan22", W'(el(res, 2, 2)), W'(32'h002C0000));
        chk("plan32", W'(el(res, 3, 2)), W'(32'hFFFFE8BB));
        chk("plan33", W'(el(res, 3, 3)), W'(32'h0003A2EC));

        do_case("ident", mkq(ident), 0, '0, res);
        chk("ident_all", res, mkq(ident));

        m = setel(mkrand(1 << 20, 1), 0, 0, '0);
        do_case("sing0", m, 0, '0, res);
        do_case("sing1", mkq(late), 0, '0, res);

        do_case("repulse", mkq(plan), 50, mkrand(1 << 20, 0), res);

        @(negedge clk); inp = mkrand(1 << 20, 1); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (99) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ans", ans, '0);
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        @(negedge clk); rst = 1'b1;
        seen = 1'b0;
        repeat (400) begin
            @(negedge clk);
            seen |= done;
        end
        chk("midrst_nodone", W'(seen), W'(0));
        mnew = mkrand(1 << 20, 1);
        do_case("after_rst", mnew, 0, '0, res);

        msat = mkrand(1 << 18, 1);
        msat = setel(msat, 0, 0, 32'h00010000);
        msat = setel(msat, 0, 1, 32'h7FFF0000);
        msat = setel(msat, 0, 2, 32'h80010000);
        msat = setel(msat, 1, 0, 32'h7FFF0000);
        msat = setel(msat, 1, 1, 32'h00010000);
        do_case("sat", msat, 0, '0, res);
        chk("sat10", W'(el(res, 1, 0)), W'(32'h7FFF0000));
        chk("sat11", W'(el(res, 1, 1)), W'(32'h80000000));
        chk("sat12", W'(el(res, 1, 2)), W'(32'h7FFFFFFF));

        for (int t = 0; t < 5; t++) begin
            do_case($sformatf("rand%0d", t), mkrand(t < 3 ? (1 << 20) : (1 << 28), 0), 0, '0, res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
